// File: rtl/clock_alarm_core.sv
// Timekeeping core: BCD time/alarm registers, second prescaler, 12/24-hour display,
// alarm with snooze and ring timeout, and hour-count chime.
module clock_alarm_core #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned ALARM_RING_SEC = 60,
  parameter int unsigned SNOOZE_MIN     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_12h,
  input  logic [1:0] set_sel,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] disp_hour,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic       pm,
  output logic       ringing,
  output logic       chime,
  output logic       sec_tick
);

  localparam int unsigned PRESC_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned ACNT_MAX     = (SNOOZE_TICKS > ALARM_RING_SEC) ? SNOOZE_TICKS
                                                                         : ALARM_RING_SEC;
  localparam int unsigned ACNT_W       = (ACNT_MAX > 1) ? $clog2(ACNT_MAX + 1) : 1;
  localparam int unsigned CHIME_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  // BCD increment with wrap to 00 after max_v
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (v == max_v) begin
      tens  = 4'd0;
      units = 4'd0;
    end else if (units == 4'd9) begin
      tens  = tens + 4'd1;
      units = 4'd0;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // 24-hour BCD hour to 12-hour binary value (00 -> 12, 13..23 -> 1..11)
  function automatic logic [4:0] hour_12(input logic [7:0] h_bcd);
    logic [4:0] b;
    logic [4:0] r;
    b = 5'(h_bcd[7:4]) * 5'd10 + 5'(h_bcd[3:0]);
    if (b == 5'd0)      r = 5'd12;
    else if (b > 5'd12) r = b - 5'd12;
    else                r = b;
    return r;
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
    logic [7:0] r;
    if (b >= 5'd10) r = {4'd1, 4'(b - 5'd10)};
    else            r = {4'd0, b[3:0]};
    return r;
  endfunction

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0]         alm_h_q, alm_h_d, alm_m_q, alm_m_d;
  alarm_state_e       state_q, state_d;
  logic [ACNT_W-1:0]  acnt_q, acnt_d;
  logic [CHIME_W-1:0] chime_ph_q, chime_ph_d;
  logic               ringing_q, ringing_d;
  logic               chime_q, chime_d;

  logic               set_time, set_alarm, presc_run, tick_c;
  logic [7:0]         roll_hh, roll_mm, roll_ss;
  logic               alarm_hit, chime_hit;
  logic [CHIME_W-1:0] chime_n;
  logic [7:0]         src_h;

  assign set_time  = (set_sel == 2'b01);
  assign set_alarm = (set_sel == 2'b10);
  assign presc_run = en && !set_time;
  assign tick_c    = presc_run && (presc_q == PRESC_W'(CLK_HZ - 1));

  // Time value one second ahead, used both for the roll and for event detection
  always_comb begin
    roll_hh = hh_q;
    roll_mm = mm_q;
    roll_ss = bcd_inc(ss_q, 8'h59);
    if (ss_q == 8'h59) begin
      roll_mm = bcd_inc(mm_q, 8'h59);
      if (mm_q == 8'h59) roll_hh = bcd_inc(hh_q, 8'h23);
    end
  end

  assign alarm_hit = tick_c && alarm_en && (roll_hh == alm_h_q) && (roll_mm == alm_m_q)
                     && (roll_ss == 8'h00);
  assign chime_hit = tick_c && (roll_mm == 8'h00) && (roll_ss == 8'h00);
  assign chime_n   = hour_12(roll_hh);

  // Prescaler, time and alarm registers
  always_comb begin
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    alm_h_d = alm_h_q;
    alm_m_d = alm_m_q;

    if (set_time)        presc_d = '0;
    else if (tick_c)     presc_d = '0;
    else if (presc_run)  presc_d = presc_q + PRESC_W'(1);

    if (set_time) begin
      if (inc_hour) hh_d = bcd_inc(hh_q, 8'h23);
      if (inc_min) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        ss_d = 8'h00;
      end
    end else if (tick_c) begin
      hh_d = roll_hh;
      mm_d = roll_mm;
      ss_d = roll_ss;
    end

    if (set_alarm) begin
      if (inc_hour) alm_h_d = bcd_inc(alm_h_q, 8'h23);
      if (inc_min)  alm_m_d = bcd_inc(alm_m_q, 8'h59);
    end
  end

  // Alarm FSM; acnt counts ring seconds up in RING and snooze seconds down in SNOOZE
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_hit) begin
          state_d = ST_RING;
          acnt_d  = '0;
        end
      end
      ST_RING: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d = ST_SNOOZE;
          acnt_d  = ACNT_W'(SNOOZE_TICKS);
        end else if (tick_c) begin
          if (acnt_q + ACNT_W'(1) >= ACNT_W'(ALARM_RING_SEC)) state_d = ST_IDLE;
          else                                                acnt_d  = acnt_q + ACNT_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          if (acnt_q <= ACNT_W'(1)) begin
            state_d = ST_RING;
            acnt_d  = '0;
          end else begin
            acnt_d  = acnt_q - ACNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!alarm_en) state_d = ST_IDLE;
  end

  // Chime phase counter: 2N phases, even non-zero phases are the audible halves
  always_comb begin
    chime_ph_d = chime_ph_q;
    if (set_time)                           chime_ph_d = '0;
    else if (chime_hit)                     chime_ph_d = chime_n + chime_n;
    else if (tick_c && chime_ph_q != '0)    chime_ph_d = chime_ph_q - CHIME_W'(1);

    ringing_d = (state_d == ST_RING);
    chime_d   = (chime_ph_d != '0) && !chime_ph_d[0] && !ringing_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      alm_h_q    <= 8'h00;
      alm_m_q    <= 8'h00;
      state_q    <= ST_IDLE;
      acnt_q     <= '0;
      chime_ph_q <= '0;
      ringing_q  <= 1'b0;
      chime_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      alm_h_q    <= alm_h_d;
      alm_m_q    <= alm_m_d;
      state_q    <= state_d;
      acnt_q     <= acnt_d;
      chime_ph_q <= chime_ph_d;
      ringing_q  <= ringing_d;
      chime_q    <= chime_d;
    end
  end

  // Display mux and 12/24-hour conversion
  always_comb begin
    src_h     = set_alarm ? alm_h_q : hh_q;
    disp_min  = set_alarm ? alm_m_q : mm_q;
    disp_sec  = set_alarm ? 8'h00 : ss_q;
    disp_hour = mode_12h ? bin_to_bcd(hour_12(src_h)) : src_h;
    pm        = mode_12h && (src_h >= 8'h12);
  end

  assign ringing  = ringing_q;
  assign chime    = chime_q;
  assign sec_tick = tick_c;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Self-checking bench for clock_alarm_core with CLK_HZ=4, ALARM_RING_SEC=3, SNOOZE_MIN=1.
module tb_clock_alarm_core;

  logic       clk = 1'b0;
  logic       rst, en, mode_12h, inc_hour, inc_min, alarm_en, snooze, stop;
  logic [1:0] set_sel;
  logic [7:0] disp_hour, disp_min, disp_sec;
  logic       pm, ringing, chime, sec_tick;

  int n_checks = 0;
  int n_errors = 0;
  int last_tick, n_ticks, n_high;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  clock_alarm_core #(
    .CLK_HZ        (4),
    .ALARM_RING_SEC(3),
    .SNOOZE_MIN    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode_12h (mode_12h),
    .set_sel  (set_sel),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .alarm_en (alarm_en),
    .snooze   (snooze),
    .stop     (stop),
    .disp_hour(disp_hour),
    .disp_min (disp_min),
    .disp_sec (disp_sec),
    .pm       (pm),
    .ringing  (ringing),
    .chime    (chime),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, got, it.exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply h hour pulses and m minute pulses in the selected set mode, overlapping them
  task automatic adjust(input logic [1:0] sel, input int h, input int m);
    set_sel = sel;
    for (int i = 0; i < ((h > m) ? h : m); i++) begin
      inc_hour = (i < h);
      inc_min  = (i < m);
      @(negedge clk);
    end
    inc_hour = 1'b0;
    inc_min  = 1'b0;
  endtask

  task automatic setup(input int th, input int tm, input int ah, input int am, input logic aen);
    en = 1'b0; alarm_en = 1'b0; mode_12h = 1'b0; stop = 1'b0; snooze = 1'b0;
    do_reset();
    adjust(2'b10, ah, am);
    adjust(2'b01, th, tm);
    alarm_en = aen;
  endtask

  task automatic go();
    set_sel = 2'b00;
    en      = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hour"}, 32'(disp_hour), 32'h00);
    check_eq({tag, "_min"}, 32'(disp_min), 32'h00);
    check_eq({tag, "_sec"}, 32'(disp_sec), 32'h00);
    check_eq({tag, "_ringing"}, 32'(ringing), 32'd0);
    check_eq({tag, "_chime"}, 32'(chime), 32'd0);
    check_eq({tag, "_tick"}, 32'(sec_tick), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode_12h = 1'b0; set_sel = 2'b00; inc_hour = 1'b0;
    inc_min = 1'b0; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state and 12-hour midnight display
    check_reset_state("rst");
    check_eq("rst_pm", 32'(pm), 32'd0);
    mode_12h = 1'b1; #1;
    check_eq("rst_hour_12h", 32'(disp_hour), 32'h12);
    check_eq("rst_pm_12h", 32'(pm), 32'd0);
    mode_12h = 1'b0;

    // en=0 freezes the prescaler
    en = 1'b0; rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("en_freeze_sec", 32'(disp_sec), 32'h00);
    en = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("en_run_sec", 32'(disp_sec), 32'h01);

    // 23:59:00 -> midnight, 12 chime beeps
    setup(23, 59, 0, 0, 1'b0);
    check_eq("set_hour", 32'(disp_hour), 32'h23);
    check_eq("set_min", 32'(disp_min), 32'h59);
    check_eq("set_sec", 32'(disp_sec), 32'h00);
    mode_12h = 1'b1; #1;
    check_eq("h12_23", 32'(disp_hour), 32'h11);
    check_eq("pm_23", 32'(pm), 32'd1);
    mode_12h = 1'b0;
    for (int j = 0; j < 100; j++) sb_push("chime_12", 32'((j < 96) && ((j % 8) < 4)));
    go();
    last_tick = 0; n_ticks = 0;
    for (int i = 1; i <= 339; i++) begin
      @(negedge clk);
      if (i <= 240 && sec_tick) begin
        if (n_ticks == 0) check_eq("first_tick", 32'(i), 32'd3);
        else              check_eq("tick_period", 32'(i - last_tick), 32'd4);
        last_tick = i;
        n_ticks++;
      end
      if (i == 240) begin
        check_eq("tick_count", 32'(n_ticks), 32'd60);
        check_eq("midnight_hour", 32'(disp_hour), 32'h00);
        check_eq("midnight_min", 32'(disp_min), 32'h00);
        check_eq("midnight_sec", 32'(disp_sec), 32'h00);
      end
      if (i >= 240) sb_pop_check(32'(chime));
    end
    check_eq("run_sec", 32'(disp_sec), 32'h24);
    set_sel = 2'b10; #1;
    check_eq("alm_view_sec", 32'(disp_sec), 32'h00);
    check_eq("alm_view_min", 32'(disp_min), 32'h00);
    set_sel = 2'b00;

    // 12/24-hour conversion and manual-set wrap without carry
    do_reset();
    adjust(2'b01, 13, 5);
    check_eq("h24_13", 32'(disp_hour), 32'h13);
    check_eq("m_05", 32'(disp_min), 32'h05);
    check_eq("pm24_13", 32'(pm), 32'd0);
    mode_12h = 1'b1; #1;
    check_eq("h12_13", 32'(disp_hour), 32'h01);
    check_eq("pm12_13", 32'(pm), 32'd1);
    mode_12h = 1'b0;
    adjust(2'b01, 0, 55);
    check_eq("min_wrap", 32'(disp_min), 32'h00);
    check_eq("min_wrap_nocarry", 32'(disp_hour), 32'h13);
    adjust(2'b01, 11, 0);
    check_eq("hour_wrap", 32'(disp_hour), 32'h00);
    do_reset();
    adjust(2'b01, 12, 0);
    mode_12h = 1'b1; #1;
    check_eq("h12_12", 32'(disp_hour), 32'h12);
    check_eq("pm12_12", 32'(pm), 32'd1);
    mode_12h = 1'b0;

    // Alarm 00:01 rings for 3 seconds
    en = 1'b0;
    do_reset();
    adjust(2'b10, 0, 1);
    check_eq("alm_set_hour", 32'(disp_hour), 32'h00);
    check_eq("alm_set_min", 32'(disp_min), 32'h01);
    alarm_en = 1'b1;
    for (int i = 236; i <= 256; i++) sb_push("ring_len", 32'((i >= 240) && (i <= 251)));
    go();
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i >= 236) sb_pop_check(32'(ringing));
    end

    // Snooze for 60 seconds, re-ring, then stop+snooze together
    setup(0, 0, 0, 1, 1'b1);
    go();
    repeat (240) @(negedge clk);
    check_eq("ring_before_snooze", 32'(ringing), 32'd1);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check_eq("snooze_quiet", 32'(ringing), 32'd0);
    n_high = 0;
    for (int i = 242; i <= 479; i++) begin
      @(negedge clk);
      if (ringing) n_high++;
    end
    check_eq("snooze_no_ring", 32'(n_high), 32'd0);
    @(negedge clk);
    check_eq("snooze_rering", 32'(ringing), 32'd1);
    stop = 1'b1; snooze = 1'b1;
    @(negedge clk);
    stop = 1'b0; snooze = 1'b0;
    check_eq("stop_wins", 32'(ringing), 32'd0);
    n_high = 0;
    repeat (300) begin
      @(negedge clk);
      if (ringing) n_high++;
    end
    check_eq("no_rering", 32'(n_high), 32'd0);

    // 14:59:59 -> 15:00:00 gives 3 beeps
    setup(14, 59, 0, 0, 1'b0);
    for (int j = 0; j <= 30; j++) sb_push("chime_3", 32'((j < 24) && ((j % 8) < 4)));
    go();
    for (int i = 1; i <= 270; i++) begin
      @(negedge clk);
      if (i == 240) begin
        check_eq("h15_hour", 32'(disp_hour), 32'h15);
        check_eq("h15_min", 32'(disp_min), 32'h00);
      end
      if (i >= 240) sb_pop_check(32'(chime));
    end

    // Alarm at 15:00 suppresses the chime while ringing; the sequence keeps counting
    setup(14, 59, 15, 0, 1'b1);
    for (int j = 0; j <= 30; j++) begin
      sb_push("ring_vs_chime_r", 32'(j <= 11));
      sb_push("ring_vs_chime_c", 32'((j >= 16) && (j <= 19)));
    end
    go();
    for (int i = 1; i <= 270; i++) begin
      @(negedge clk);
      if (i >= 240) begin
        sb_pop_check(32'(ringing));
        sb_pop_check(32'(chime));
      end
    end

    // Reset mid-chime
    setup(14, 59, 0, 0, 1'b0);
    go();
    repeat (242) @(negedge clk);
    check_eq("pre_rst_chime", 32'(chime), 32'd1);
    do_reset();
    check_reset_state("rst_chime");
    n_high = 0;
    repeat (40) begin
      @(negedge clk);
      if (chime) n_high++;
    end
    check_eq("rst_chime_quiet", 32'(n_high), 32'd0);

    // Reset mid-ring
    setup(14, 59, 15, 0, 1'b1);
    go();
    repeat (245) @(negedge clk);
    check_eq("pre_rst_ring", 32'(ringing), 32'd1);
    do_reset();
    check_reset_state("rst_ring");
    n_high = 0;
    repeat (40) begin
      @(negedge clk);
      if (ringing) n_high++;
    end
    check_eq("rst_ring_quiet", 32'(n_high), 32'd0);
    alarm_en = 1'b0;

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
